// File: rtl/countdown_key_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_key_ctrl
//
// Control stage that sits directly in front of the BCD ones/tens down-counters.
// It debounces the two raw pushbuttons into single-clock press events. It runs
// an IDLE/RUN/PAUSE/DONE FSM that passes divider ticks through as counter
// enables, and it requests a reload to 99. The countdown stops at 00 and the
// alarm LED is lit.
//
// Parameters
//   DB_CYCLES  clocks a synchronised key level must hold before it is accepted
//   DB_W       debounce counter width, 2**DB_W > DB_CYCLES
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous reset, active low
//   key_start_n  in   raw start/pause button, active low, asynchronous
//   key_clear_n  in   raw clear button, active low, asynchronous
//   tick         in   one-clock pulse at the count rate (clk domain)
//   ones_zero    in   ones digit is 0
//   tens_zero    in   tens digit is 0
//   count_en     out  one-clock enable pulse to the counters
//   count_load   out  one-clock pulse: counters reload to 9/9
//   state        out  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   alarm_led    out  alarm indicator, active in DONE
//
// Build option
//   ALARM_BLINK_EN  defined: alarm_led toggles on every tick while in DONE
//                   (it is 0 on DONE entry and is cleared on leaving DONE).
//                   undefined: alarm_led is steady 1 in DONE.
// -----------------------------------------------------------------------------
module countdown_key_ctrl #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic       tick,
  input  logic       ones_zero,
  input  logic       tens_zero,
  output logic       count_en,
  output logic       count_load,
  output logic [1:0] state,
  output logic       alarm_led
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam int KEY_START = 0;
  localparam int KEY_CLEAR = 1;

  logic [1:0] key_n;
  logic [1:0] press;

  assign key_n = {key_clear_n, key_start_n};

  // ---------------------------------------------------------------------------
  // Key path: 2-FF synchroniser followed by a stability counter.
  // The press event is raised in the clock in which a debounced 1->0 change is
  // accepted, so the FSM reacts on the same edge the debounced level falls.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            differ;
    logic            accept;

    // NOTE: every flop here is a handful of bits, so all of them are reset;
    // nothing in this block is a memory that would need to stay unreset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        level_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        // NOTE: non-blocking assignments make the two synchroniser stages a
        // real shift register; blocking ones would collapse them into one.
        sync1_q <= key_n[k];
        sync2_q <= sync1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

    assign differ = (sync2_q != level_q);
    assign accept = differ && (cnt_q == DB_LAST);

    // The counter only advances on consecutive disagreement and clears both
    // on agreement and on acceptance, so it can never wrap.
    always_comb begin
      // NOTE: defaults first so every path assigns every output; a missing
      // branch would otherwise infer a latch.
      level_d = level_q;
      cnt_d   = '0;
      if (differ) begin
        if (accept) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    assign press[k] = accept && !sync2_q;
  end

  // ---------------------------------------------------------------------------
  // Control FSM. All outputs are registered alongside the state.
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   en_q, en_d;
  logic   load_q, load_d;
  logic   alarm_q, alarm_d;
  logic   start_evt, clear_evt, at_zero;

  assign start_evt = press[KEY_START];
  assign clear_evt = press[KEY_CLEAR];
  assign at_zero   = ones_zero && tens_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      load_q  <= load_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    load_d  = 1'b0;
    if (clear_evt) begin
      // Clear overrides any start event arriving in the same clock.
      load_d  = 1'b1;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_evt) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Start has priority over a coincident tick.
          if (start_evt) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            // Suppress the enable at 00 so the display holds 00.
            if (at_zero) state_d = ST_DONE;
            else         en_d    = 1'b1;
          end
        end
        ST_PAUSE: begin
          // Ticks are dropped here, not remembered.
          if (start_evt) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (start_evt) begin
            load_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef ALARM_BLINK_EN
  // Toggle only while staying in DONE; entering or leaving DONE forces 0.
  always_comb begin
    alarm_d = 1'b0;
    if (state_d == ST_DONE && state_q == ST_DONE) begin
      alarm_d = tick ? !alarm_q : alarm_q;
    end
  end
`else
  always_comb begin
    alarm_d = (state_d == ST_DONE);
  end
`endif

  assign count_en   = en_q;
  assign count_load = load_q;
  assign state      = state_q;
  assign alarm_led  = alarm_q;

endmodule
